mini_alu_mc: RTL and testbench

MINI_ALU_MC -- requirements
Module: mini_alu_mc

---
 rtl/mini_alu_mc_pkg.sv | 40 ++++
 rtl/mini_alu_mc_if.sv | 25 ++
 rtl/mini_alu_mc_seq_mul.sv | 52 +++++
 rtl/mini_alu_mc.sv | 166 ++++++++++++++++
 tb/tb_mini_alu_mc.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mini_alu_mc_pkg.sv
// Shared opcodes, execute-state encoding and instruction field offsets for mini_alu_mc.
// IMUL support is enabled by the MINI_ALU_MC_MUL_EN macro (see mini_alu_mc.sv).
package mini_alu_mc_pkg;

  localparam int unsigned OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_NOP  = 4'd0;
  localparam logic [OPC_W-1:0] OP_LED  = 4'd1;
  localparam logic [OPC_W-1:0] OP_BLE  = 4'd2;
  localparam logic [OPC_W-1:0] OP_STO  = 4'd3;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'd4;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'd5;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'd6;
  localparam logic [OPC_W-1:0] OP_IMUL = 4'd7;
  localparam logic [OPC_W-1:0] OP_HLT  = 4'd8;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_MUL  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // Instruction word is {opcode, dest, src1, src0}, MSB first.
  function automatic int unsigned src0_lsb(input int unsigned aw);
    return 0;
  endfunction

  function automatic int unsigned src1_lsb(input int unsigned aw);
    return aw;
  endfunction

  function automatic int unsigned dest_lsb(input int unsigned aw);
    return 2 * aw;
  endfunction

  function automatic int unsigned opc_lsb(input int unsigned aw);
    return 3 * aw;
  endfunction

endpackage

// File: rtl/mini_alu_mc_if.sv
// Instruction-fetch and status bundle between mini_alu_mc and its ROM/observer.
interface mini_alu_mc_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned IP_W   = 16,
  parameter int unsigned LED_W  = 8
);
  import mini_alu_mc_pkg::*;

  logic [OPC_W+3*ADDR_W-1:0] iInstruction;
  logic [IP_W-1:0]           oIP;
  logic [LED_W-1:0]          oLed;
  logic                      oBusy;
  logic                      oHalted;

  modport master (
    output iInstruction,
    input  oIP, oLed, oBusy, oHalted
  );

  modport slave (
    input  iInstruction,
    output oIP, oLed, oBusy, oHalted
  );

endinterface

// File: rtl/mini_alu_mc_seq_mul.sv
// Unsigned shift-add multiplier: one partial product per cycle, DATA_W cycles per operation.
module seq_mul #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_c_o,
  output logic [DATA_W-1:0] product_c_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] addend;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;

  // Product includes the step taken at the final edge, so the result is ready as busy drops.
  assign addend      = mplier_q[0] ? mcand_q : '0;
  assign product_c_o = acc_q + addend;
  assign done_c_o    = busy_q && (cnt_q == CNT_W'(DATA_W - 1));
  assign busy_o      = busy_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (start_i && !busy_q) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
    end else if (busy_q) begin
      acc_q    <= product_c_o;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
      if (done_c_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/mini_alu_mc.sv
// Two-stage (fetch/execute) accumulator-less ALU core with a 2^ADDR_W-entry register file.
// Define MINI_ALU_MC_MUL_EN to build the multi-cycle IMUL; otherwise IMUL runs as NOP.
module mini_alu_mc
  import mini_alu_mc_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned IP_W   = 16,
  parameter int unsigned LED_W  = 8
) (
  input  logic          Clock,
  input  logic          Reset,
  mini_alu_mc_if.slave  bus
);

  localparam int unsigned INSTR_W  = OPC_W + 3 * ADDR_W;
  localparam int unsigned SRC0_LSB = src0_lsb(ADDR_W);
  localparam int unsigned SRC1_LSB = src1_lsb(ADDR_W);
  localparam int unsigned DEST_LSB = dest_lsb(ADDR_W);
  localparam int unsigned OPC_LSB  = opc_lsb(ADDR_W);

  state_e              state_q, state_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [IP_W-1:0]     ip_q, ip_d;
  logic [LED_W-1:0]    led_q, led_d;
  logic                halted_q;

  logic [DATA_W-1:0]   rf [2**ADDR_W];
  logic                rf_we;
  logic [DATA_W-1:0]   rf_wdata;

  logic [OPC_W-1:0]    opc;
  logic [ADDR_W-1:0]   dest, src1, src0;
  logic [DATA_W-1:0]   rs1, rs0;
  logic [2*ADDR_W-1:0] imm;

  logic                mul_done_c;
  logic [DATA_W-1:0]   mul_product_c;

  assign opc  = ir_q[OPC_LSB  +: OPC_W];
  assign dest = ir_q[DEST_LSB +: ADDR_W];
  assign src1 = ir_q[SRC1_LSB +: ADDR_W];
  assign src0 = ir_q[SRC0_LSB +: ADDR_W];
  assign imm  = {src1, src0};
  assign rs1  = rf[src1];
  assign rs0  = rf[src0];

`ifdef MINI_ALU_MC_MUL_EN
  logic mul_start;
  logic mul_busy;

  seq_mul #(
    .DATA_W (DATA_W)
  ) u_seq_mul (
    .clk_i       (Clock),
    .rst_i       (Reset),
    .start_i     (mul_start),
    .a_i         (rs1),
    .b_i         (rs0),
    .busy_o      (mul_busy),
    .done_c_o    (mul_done_c),
    .product_c_o (mul_product_c)
  );

  assign bus.oBusy = mul_busy;
`else
  assign mul_done_c    = 1'b0;
  assign mul_product_c = '0;
  assign bus.oBusy     = 1'b0;
`endif

  // Execute decode and fetch control; IR/IP advance only in ST_RUN or as IMUL completes.
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    ip_d     = ip_q;
    led_d    = led_q;
    rf_we    = 1'b0;
    rf_wdata = '0;
`ifdef MINI_ALU_MC_MUL_EN
    mul_start = 1'b0;
`endif
    case (state_q)
      ST_RUN: begin
        ir_d = bus.iInstruction;
        ip_d = ip_q + IP_W'(1);
        case (opc)
          OP_ADD: begin
            rf_we    = 1'b1;
            rf_wdata = rs1 + rs0;
          end
          OP_SUB: begin
            rf_we    = 1'b1;
            rf_wdata = rs1 - rs0;
          end
          OP_STO: begin
            rf_we    = 1'b1;
            rf_wdata = DATA_W'(imm);
          end
          OP_LED: led_d = rs1[LED_W-1:0];
          OP_JMP: begin
            ip_d = IP_W'(dest);
            ir_d = '0;
          end
          OP_BLE: begin
            if (rs1 <= rs0) begin
              ip_d = IP_W'(dest);
              ir_d = '0;
            end
          end
`ifdef MINI_ALU_MC_MUL_EN
          OP_IMUL: begin
            mul_start = 1'b1;
            state_d   = ST_MUL;
            ir_d      = ir_q;
            ip_d      = ip_q;
          end
`endif
          OP_HLT: begin
            state_d = ST_HALT;
            ir_d    = ir_q;
            ip_d    = ip_q;
          end
          default: ;
        endcase
      end
      ST_MUL: begin
        if (mul_done_c) begin
          rf_we    = 1'b1;
          rf_wdata = mul_product_c;
          state_d  = ST_RUN;
          ir_d     = bus.iInstruction;
          ip_d     = ip_q + IP_W'(1);
        end
      end
      ST_HALT: ;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= ST_RUN;
      ir_q     <= '0;
      ip_q     <= '0;
      led_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      ip_q     <= ip_d;
      led_q    <= led_d;
      halted_q <= (state_d == ST_HALT);
    end
  end

  // Register file is not reset; Reset only suppresses a pending write.
  always_ff @(posedge Clock) begin
    if (rf_we && !Reset) rf[dest] <= rf_wdata;
  end

  assign bus.oIP     = ip_q;
  assign bus.oLed    = led_q;
  assign bus.oHalted = halted_q;

endmodule

// File: tb/tb_mini_alu_mc.sv
// Directed program run on mini_alu_mc with a queue of expected observations.
module tb_mini_alu_mc;
  import mini_alu_mc_pkg::*;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned IP_W   = 16;
  localparam int unsigned LED_W  = 8;
  localparam int unsigned IW     = OPC_W + 3 * ADDR_W;

`ifdef MINI_ALU_MC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mini_alu_mc_if #(.ADDR_W(ADDR_W), .IP_W(IP_W), .LED_W(LED_W)) bus ();

  mini_alu_mc #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .IP_W   (IP_W),
    .LED_W  (LED_W)
  ) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  logic [IW-1:0] rom [256];
  assign bus.iInstruction = rom[bus.oIP[7:0]];

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_t;

  sb_t sb[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  function automatic logic [IW-1:0] enc(input logic [3:0] op, input logic [7:0] d,
                                        input logic [7:0] s1, input logic [7:0] s0);
    return {op, d, s1, s0};
  endfunction

  function automatic logic [IW-1:0] sto(input logic [7:0] d, input logic [15:0] v);
    return {OP_STO, d, v};
  endfunction

  task automatic push_exp(input string tag, input logic [31:0] v);
    sb_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    sb_t e;
    if (sb.size() == 0) begin
      e.tag = "queue_empty";
      e.val = 'x;
    end else begin
      e = sb.pop_front();
    end
    n_checks++;
    assert (obs === e.val && tag == e.tag) n_pass++;
    else $error("FAIL %s observed=%h expected=%h (queued %s)", tag, obs, e.val, e.tag);
  endtask

  task automatic wait_ip(input logic [IP_W-1:0] v, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (bus.oIP === v) seen = 1'b1;
    end
    n_checks++;
    assert (seen) n_pass++;
    else $error("FAIL %s timeout observed=%h expected=%h", tag, bus.oIP, v);
  endtask

  initial begin
    int busy_cnt;
    int busy_ip_moved;
    logic [15:0] prod;

    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[8'h00] = sto(8'd1, 16'd5);
    rom[8'h01] = sto(8'd2, 16'd3);
    rom[8'h02] = sto(8'd5, 16'hFFFF);
    rom[8'h03] = sto(8'd6, 16'd1);
    rom[8'h04] = sto(8'd7, 16'd6);
    rom[8'h05] = sto(8'd9, 16'h0011);
    rom[8'h06] = enc(OP_ADD, 8'd3, 8'd1, 8'd2);
    rom[8'h07] = enc(OP_LED, 8'd0, 8'd3, 8'd0);
    rom[8'h08] = enc(OP_SUB, 8'd4, 8'd2, 8'd1);
    rom[8'h09] = enc(OP_ADD, 8'd8, 8'd5, 8'd6);
    rom[8'h0A] = enc(OP_BLE, 8'h20, 8'd2, 8'd1);
    rom[8'h0B] = sto(8'd9, 16'h0099);
    rom[8'h20] = enc(OP_BLE, 8'h40, 8'd7, 8'd1);
    rom[8'h21] = sto(8'd10, 16'h0077);
    rom[8'h22] = sto(8'd11, 16'd300);
    rom[8'h23] = sto(8'd12, 16'h1234);
    rom[8'h24] = enc(OP_IMUL, 8'd12, 8'd11, 8'd11);
    rom[8'h25] = enc(OP_LED, 8'd0, 8'd12, 8'd0);
    rom[8'h26] = enc(OP_JMP, 8'h30, 8'd0, 8'd0);
    rom[8'h27] = sto(8'd9, 16'h0066);
    rom[8'h30] = enc(OP_HLT, 8'd0, 8'd0, 8'd0);
    rom[8'h31] = sto(8'd10, 16'h00AB);

    prod = MUL_EN ? 16'(32'd300 * 32'd300) : 16'h1234;

    push_exp("rst_ip", 0);
    push_exp("rst_led", 0);
    push_exp("rst_busy", 0);
    push_exp("rst_halted", 0);
    push_exp("led_add", 8);
    push_exp("br_taken", 32'h20);
    push_exp("br_fetch", 32'h21);
    push_exp("br_not_taken", 32'h22);
    push_exp("busy_cycles", MUL_EN ? 16 : 0);
    push_exp("busy_ip_moved", 0);
    push_exp("halted", 1);
    push_exp("halt_ip", 32'h31);
    push_exp("halt_ip_hold", 32'h31);
    push_exp("halt_still", 1);
    push_exp("r3", 8);
    push_exp("r4", 32'hFFFE);
    push_exp("r8", 0);
    push_exp("r9", 32'h11);
    push_exp("r10", 32'h77);
    push_exp("r12", 32'(prod));
    push_exp("led_final", 32'(prod[7:0]));

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ip", 32'(bus.oIP));
    check("rst_led", 32'(bus.oLed));
    check("rst_busy", 32'(bus.oBusy));
    check("rst_halted", 32'(bus.oHalted));
    rst = 1'b0;

    wait_ip(16'd9, "wait_led");
    check("led_add", 32'(bus.oLed));
    wait_ip(16'd11, "wait_ble");
    @(negedge clk);
    check("br_taken", 32'(bus.oIP));
    @(negedge clk);
    check("br_fetch", 32'(bus.oIP));
    @(negedge clk);
    check("br_not_taken", 32'(bus.oIP));

    busy_cnt = 0;
    busy_ip_moved = 0;
    for (int i = 0; i < 300 && bus.oHalted !== 1'b1; i++) begin
      @(negedge clk);
      if (bus.oBusy === 1'b1) begin
        busy_cnt++;
        if (bus.oIP !== 16'h25) busy_ip_moved++;
      end
    end
    check("busy_cycles", 32'(busy_cnt));
    check("busy_ip_moved", 32'(busy_ip_moved));
    check("halted", 32'(bus.oHalted));
    check("halt_ip", 32'(bus.oIP));
    repeat (5) @(negedge clk);
    check("halt_ip_hold", 32'(bus.oIP));
    check("halt_still", 32'(bus.oHalted));
    check("r3", 32'(dut.rf[3]));
    check("r4", 32'(dut.rf[4]));
    check("r8", 32'(dut.rf[8]));
    check("r9", 32'(dut.rf[9]));
    check("r10", 32'(dut.rf[10]));
    check("r12", 32'(dut.rf[12]));
    check("led_final", 32'(bus.oLed));

    // Second pass: restart the program and reset in the middle of IMUL.
    push_exp("mid_busy", 32'(MUL_EN));
    push_exp("mid_led", MUL_EN ? 8 : 32'h34);
    push_exp("rr_ip", 0);
    push_exp("rr_led", 0);
    push_exp("rr_busy", 0);
    push_exp("rr_halted", 0);
    push_exp("rr_r12", 32'h1234);
    push_exp("rr_fetch", 1);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_ip(16'h25, "wait_imul");
    repeat (3) @(negedge clk);
    check("mid_busy", 32'(bus.oBusy));
    check("mid_led", 32'(bus.oLed));
    rst = 1'b1;
    @(negedge clk);
    check("rr_ip", 32'(bus.oIP));
    check("rr_led", 32'(bus.oLed));
    check("rr_busy", 32'(bus.oBusy));
    check("rr_halted", 32'(bus.oHalted));
    check("rr_r12", 32'(dut.rf[12]));
    rst = 1'b0;
    @(negedge clk);
    check("rr_fetch", 32'(bus.oIP));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
